// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Circular return-address stack for CALL/RET resolution in EX.
//               CALL pushes push_pc+2 (skips the delay slot); RET pops and
//               presents the target combinationally on ret_addr. Tracks
//               occupancy and keeps sticky overflow/underflow flags.
//               Optional macro RETURN_STACK_HWM_EN adds a max_count output
//               holding the occupancy high-water mark since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   push_pc,
    input  logic          pop,
    input  logic          stall,
    input  logic          flag_clr,
    output logic [15:0]   ret_addr,
    output logic          ret_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
`ifdef RETURN_STACK_HWM_EN
    output logic [AW:0]   max_count,
`endif
    output logic          underflow
);

    localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
    localparam logic [AW-1:0] c_sp_one    = AW'(1);

    logic [15:0]   r_stack [DEPTH];
    logic [AW-1:0] r_sp;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_eff_push;
    logic          w_eff_pop;
    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_top_idx;
    logic [15:0]   w_push_val;
    logic [AW-1:0] w_sp_nxt;
    logic [AW:0]   w_count_nxt;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic          w_ovf_set;
    logic          w_unf_set;

    assign w_eff_push = push & ~stall;
    assign w_eff_pop  = pop  & ~stall;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    assign w_top_idx  = r_sp - c_sp_one;
    // Return lands after the delay slot; wraps modulo 2^16.
    assign w_push_val = push_pc + 16'd2;

    // Decode the effective command into pointer/count/write/flag updates.
    always_comb begin
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_sp;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case ({w_eff_push, w_eff_pop})
            2'b10: begin
                // When full, sp points at the oldest entry, so it is overwritten.
                w_wr_en  = 1'b1;
                w_wr_idx = r_sp;
                w_sp_nxt = r_sp + c_sp_one;
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count + c_cnt_one;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_sp_nxt    = r_sp - c_sp_one;
                    w_count_nxt = r_count - c_cnt_one;
                end
            end
            2'b11: begin
                if (w_empty) begin
                    // Pop half underflows; push half then applies normally.
                    w_unf_set   = 1'b1;
                    w_wr_en     = 1'b1;
                    w_wr_idx    = r_sp;
                    w_sp_nxt    = r_sp + c_sp_one;
                    w_count_nxt = c_cnt_one;
                end else begin
                    // Tail-call style replace of the top entry in place.
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_top_idx;
                end
            end
            default: ;
        endcase
    end

    // Pointer, occupancy and sticky error flags; a new error beats flag_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_set | (r_overflow  & ~flag_clr);
            r_underflow <= w_unf_set | (r_underflow & ~flag_clr);
        end
    end

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack[w_wr_idx] <= w_push_val;
        end
    end

`ifdef RETURN_STACK_HWM_EN
    logic [AW:0] r_max_count;

    // High-water mark of occupancy; unaffected by flag_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_count <= '0;
        end else if (w_count_nxt > r_max_count) begin
            r_max_count <= w_count_nxt;
        end
    end

    assign max_count = r_max_count;
`endif

    assign ret_addr  = w_empty ? 16'h0000 : r_stack[w_top_idx];
    assign ret_valid = ~w_empty;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_stack
// Description : Directed self-checking bench for return_stack (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [15:0] push_pc;
    logic        pop;
    logic        stall;
    logic        flag_clr;
    logic [15:0] ret_addr;
    logic        ret_valid;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;
    logic        underflow;
`ifdef RETURN_STACK_HWM_EN
    logic [AW:0] max_count;
`endif

    int errors = 0;
    int checks = 0;

    return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (push_pc),
        .pop       (pop),
        .stall     (stall),
        .flag_clr  (flag_clr),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
`ifdef RETURN_STACK_HWM_EN
        .max_count (max_count),
`endif
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one command for one clock edge, then return inputs to idle.
    task automatic cyc(input logic p, input logic [15:0] pc, input logic q,
                       input logic s, input logic c);
        push = p; push_pc = pc; pop = q; stall = s; flag_clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; stall = 1'b0; flag_clr = 1'b0; push_pc = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; push_pc = 16'h0000; pop = 1'b0;
        stall = 1'b0; flag_clr = 1'b0;
        #12;
        chk("rst_count",     16'(count),     16'h0);
        chk("rst_empty",     16'(empty),     16'h1);
        chk("rst_full",      16'(full),      16'h0);
        chk("rst_valid",     16'(ret_valid), 16'h0);
        chk("rst_ret_addr",  ret_addr,       16'h0000);
        chk("rst_overflow",  16'(overflow),  16'h0);
        chk("rst_underflow", 16'(underflow), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pop on an empty stack.
        cyc(0, 16'h0, 1, 0, 0);
        chk("emptypop_ret_addr",  ret_addr,       16'h0000);
        chk("emptypop_underflow", 16'(underflow), 16'h1);
        chk("emptypop_count",     16'(count),     16'h0);
        chk("emptypop_empty",     16'(empty),     16'h1);
        cyc(0, 16'h0, 0, 0, 1);
        chk("clr_underflow", 16'(underflow), 16'h0);

        // Three pushes then LIFO pops.
        cyc(1, 16'h1000, 0, 0, 0);
        cyc(1, 16'h2000, 0, 0, 0);
        cyc(1, 16'h3000, 0, 0, 0);
        chk("push3_ret_addr", ret_addr,       16'h3002);
        chk("push3_count",    16'(count),     16'h3);
        chk("push3_valid",    16'(ret_valid), 16'h1);
        chk("pop_a", ret_addr, 16'h3002);
        cyc(0, 16'h0, 1, 0, 0);
        chk("pop_b", ret_addr, 16'h2002);
        cyc(0, 16'h0, 1, 0, 0);
        chk("pop_c", ret_addr, 16'h1002);
        cyc(0, 16'h0, 1, 0, 0);
        chk("pop3_empty",     16'(empty),     16'h1);
        chk("pop3_ret_addr",  ret_addr,       16'h0000);
        chk("pop3_underflow", 16'(underflow), 16'h0);

        // Ten pushes into an eight-deep stack: oldest two are lost.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h0010 + 16'(i), 0, 0, 0);
        end
        chk("wrap_full",     16'(full),     16'h1);
        chk("wrap_overflow", 16'(overflow), 16'h1);
        chk("wrap_count",    16'(count),    16'h8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_pop", ret_addr, 16'h001B - 16'(i));
            cyc(0, 16'h0, 1, 0, 0);
        end
        chk("wrap_empty",   16'(empty),     16'h1);
        chk("wrap_no_unf",  16'(underflow), 16'h0);
        cyc(0, 16'h0, 1, 0, 0);
        chk("wrap_9th_unf", 16'(underflow), 16'h1);

        // Simultaneous push and pop.
        cyc(0, 16'h0, 0, 0, 1);
        chk("clr_both_ovf", 16'(overflow),  16'h0);
        chk("clr_both_unf", 16'(underflow), 16'h0);
        cyc(1, 16'h0040, 0, 0, 0);
        chk("pp_pre_top", ret_addr, 16'h0042);
        cyc(1, 16'h0100, 1, 0, 0);
        chk("pp_count",    16'(count),     16'h1);
        chk("pp_ret_addr", ret_addr,       16'h0102);
        chk("pp_no_unf",   16'(underflow), 16'h0);
        chk("pp_no_ovf",   16'(overflow),  16'h0);
        cyc(0, 16'h0, 1, 0, 0);
        chk("pp_pop_empty", 16'(empty), 16'h1);
        cyc(1, 16'h0100, 1, 0, 0);
        chk("ppe_count",     16'(count),     16'h1);
        chk("ppe_underflow", 16'(underflow), 16'h1);
        chk("ppe_ret_addr",  ret_addr,       16'h0102);

        // Stall blocks push/pop.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h5555, 1, 1, 0);
        end
        chk("stall_count",    16'(count), 16'h1);
        chk("stall_ret_addr", ret_addr,   16'h0102);
        cyc(1, 16'h6666, 0, 1, 0);
        chk("stall_push_count", 16'(count), 16'h1);
        cyc(0, 16'h0, 1, 1, 0);
        chk("stall_pop_count",  16'(count), 16'h1);
        chk("stall_pop_top",    ret_addr,   16'h0102);

        // Fill, overflow, then flag_clr racing a new overflow.
        for (int i = 0; i < 7; i++) begin
            cyc(1, 16'h0200 + 16'(i), 0, 0, 0);
        end
        chk("fill_full",   16'(full),     16'h1);
        chk("fill_no_ovf", 16'(overflow), 16'h0);
        cyc(1, 16'h0300, 0, 0, 0);
        chk("ovf_set", 16'(overflow), 16'h1);
        cyc(1, 16'h0400, 0, 0, 1);
        chk("clr_race_ovf", 16'(overflow),  16'h1);
        chk("clr_race_unf", 16'(underflow), 16'h0);
        chk("clr_race_top", ret_addr,       16'h0402);
        cyc(0, 16'h0, 0, 0, 1);
        chk("clr_alone_ovf", 16'(overflow),  16'h0);
        chk("clr_alone_unf", 16'(underflow), 16'h0);

        // Asynchronous reset without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("arst_count", 16'(count), 16'h0);
        chk("arst_empty", 16'(empty), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // High-water mark scenario: push 5, pop 3, push 1.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'h0A00 + 16'(i), 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0, 1, 0, 0);
        end
        cyc(1, 16'h0B00, 0, 0, 0);
        chk("hwm_count", 16'(count), 16'h3);
        chk("hwm_top",   ret_addr,   16'h0B02);
`ifdef RETURN_STACK_HWM_EN
        chk("hwm_max", 16'(max_count), 16'h5);
        cyc(0, 16'h0, 0, 0, 1);
        chk("hwm_max_after_clr", 16'(max_count), 16'h5);
`endif

        // Address wrap at the top of the 16-bit space.
        cyc(1, 16'hFFFF, 0, 0, 0);
        chk("pc_ffff", ret_addr, 16'h0001);
        cyc(1, 16'hFFFE, 0, 0, 0);
        chk("pc_fffe",       ret_addr,       16'h0000);
        chk("pc_fffe_valid", 16'(ret_valid), 16'h1);
        chk("pc_fffe_count", 16'(count),     16'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
